// File: rtl/gol_display_pkg.sv
// Shared definitions for the Game of Life display path: converter FSM
// states, BCD nibble width, decimal range helper and the all-nines pattern.
package gol_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Up to 16 digits of nines; users slice off the low NIB_W*DIGITS bits.
    localparam logic [63:0] ALL_NINES = {16{4'h9}};

    // Largest decimal value representable with the given number of digits.
    function automatic longint unsigned dec_max(input int digits);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
// master = requester (drives start/bin_in), slave = the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble correction: every BCD nibble that is 5 or more gets +3 so
// that the following left shift carries correctly into the next decade.
module bcd_add3_adjust
    import gol_display_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [NIB_W*DIGITS-1:0] bcd_in,
    output logic [NIB_W*DIGITS-1:0] bcd_adj
);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            // Per-nibble conditional add of 3
            assign bcd_adj[gi*NIB_W +: NIB_W] =
                (bcd_in[gi*NIB_W +: NIB_W] >= 4'd5) ?
                    bcd_in[gi*NIB_W +: NIB_W] + 4'd3 :
                    bcd_in[gi*NIB_W +: NIB_W];
        end
    endgenerate

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional build macro BIN_TO_BCD_SATURATE_EN: out-of-range inputs produce
// all nines instead of bin_in mod 10^DIGITS.
module bin_to_bcd_seq
    import gol_display_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic               clock_100Mhz,
    input  logic               reset,
    bin_to_bcd_seq_if.slave    bus
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int IT_W  = $clog2(BIN_W + 1);
    localparam logic [IT_W-1:0] LAST_ITER = IT_W'(BIN_W - 1);
    localparam longint unsigned DMAX = dec_max(DIGITS);
`ifdef BIN_TO_BCD_SATURATE_EN
    localparam logic [BCD_W-1:0] NINES = ALL_NINES[BCD_W-1:0];
`endif

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_shifted;

    bcd_add3_adjust #(
        .DIGITS (DIGITS)
    ) u_add3 (
        .bcd_in  (scratch_q),
        .bcd_adj (scratch_adj)
    );

    // Top bit of the adjusted scratch falls off, giving bin_in mod 10^DIGITS.
    assign scratch_shifted = {scratch_adj[BCD_W-2:0], shift_q[BIN_W-1]};

    // Next-state and datapath: the result register is loaded on the final
    // shift so it becomes visible together with the done pulse.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.bin_in;
                    scratch_d  = '0;
                    iter_d     = '0;
                    ovf_pend_d = (64'(bus.bin_in) > DMAX);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_shifted;
                shift_d   = {shift_q[BIN_W-2:0], 1'b0};
                iter_d    = iter_q + 1'b1;
                if (iter_q == LAST_ITER) begin
                    state_d = DONE;
                    ovf_d   = ovf_pend_q;
`ifdef BIN_TO_BCD_SATURATE_EN
                    bcd_d   = ovf_pend_q ? NINES : scratch_shifted;
`else
                    bcd_d   = scratch_shifted;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = BIN_W + 1;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int unsigned val;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle_cnt;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clock_100Mhz (clk),
        .reset        (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Reference model: decimal digits of the value, computed arithmetically.
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned m;
        e.val = v;
        e.ovf = (v > 9999);
        m     = v % 10000;
        e.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BIN_TO_BCD_SATURATE_EN
        if (e.ovf) e.bcd = 16'h9999;
`endif
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle_cnt);
        end
    endtask

    // Issue start at the current cycle; returns the acceptance cycle index.
    task automatic start_conv(input int unsigned v, output int t0);
        bus.start  = 1'b1;
        bus.bin_in = BIN_W'(v);
        exp_q.push_back(model(v));
        t0 = cycle_cnt;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bin_in = BIN_W'($urandom);
        check("busy_cycle1", longint'(bus.busy), 1);
    endtask

    task automatic wait_done(input int t0);
        int k;
        k = 0;
        while (!bus.done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        else           check("done_latency", longint'(cycle_cnt - t0), LAT);
    endtask

    task automatic run_one(input int unsigned v);
        int t0;
        start_conv(v, t0);
        wait_done(t0);
        @(posedge clk); #1;
    endtask

    // Monitor: protocol invariants every cycle, data check on each done.
    logic        done_prev;
    logic        rst_prev;
    logic [15:0] bcd_prev;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("done_busy_overlap", longint'(bus.done & bus.busy), 0);
            check("done_width", longint'(bus.done & done_prev), 0);
            for (int i = 0; i < DIGITS; i++) begin
                n_chk++;
                if (bus.bcd_out[4*i +: 4] > 4'd9) begin
                    n_fail++;
                    $display("FAIL nibble_range: got %0h required <=9 (digit %0d)", bus.bcd_out[4*i +: 4], i);
                end
            end
            if (!rst_prev && !bus.done) check("bcd_stable", longint'(bus.bcd_out), longint'(bcd_prev));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn bin_in=%0d bcd_out=%04h overflow=%0b", e.val, bus.bcd_out, bus.overflow);
                    check("bcd_out", longint'(bus.bcd_out), longint'(e.bcd));
                    check("overflow", longint'(bus.overflow), longint'(e.ovf));
                end
            end
        end
        done_prev = bus.done;
        rst_prev  = rst;
        bcd_prev  = bus.bcd_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        cycle_cnt  = 0;
        n_chk      = 0;
        n_fail     = 0;
        done_prev  = 1'b0;
        rst_prev   = 1'b1;
        bcd_prev   = '0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_bcd", longint'(bus.bcd_out), 0);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_done", longint'(bus.done), 0);
        check("reset_ovf", longint'(bus.overflow), 0);

        // Directed values including range boundaries and overflow
        run_one(1234);
        run_one(0);
        run_one(9999);
        run_one(10000);
        run_one(12345);
        run_one(16383);

        // Start during busy is ignored and bin_in changes have no effect
        start_conv(42, t0);
        while (cycle_cnt < t0 + 5) begin @(posedge clk); #1; end
        bus.start  = 1'b1;
        bus.bin_in = 14'd77;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bin_in = 14'd3333;
        wait_done(t0);
        // Start held through the DONE cycle must not be taken there
        bus.start  = 1'b1;
        bus.bin_in = 14'd55;
        @(posedge clk); #1;
        check("idle_after_done", longint'(bus.busy), 0);
        bus.start  = 1'b0;
        run_one(77);

        // Reset mid-conversion aborts without a done pulse
        run_one(1234);
        start_conv(500, t0);
        while (cycle_cnt < t0 + 7) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_bcd", longint'(bus.bcd_out), 0);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_ovf", longint'(bus.overflow), 0);
        repeat (20) @(posedge clk);
        #1;
        run_one(500);

        // Back-to-back random conversions
        for (int i = 0; i < 200; i++) run_one($urandom_range(0, 9999));
        for (int i = 0; i < 20; i++)  run_one($urandom_range(0, 16383));

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", longint'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble converter that turns a binary count (e.g. Game of Life generation / live-cell count) into packed BCD digits.
- Sits directly upstream of the seven-segment display controller; its registered BCD output drives the digit-select/cathode decode so the display needs no divide/modulo logic.
- Uses a start/busy/done handshake. The output holds its last valid result while a new conversion runs.

Parameters:
- BIN_W, 14, width of binary input (14 bits covers 0..16383).
- DIGITS, 4, number of BCD digits produced (4 gives a range of 0..9999).

Ports:
- clock_100Mhz  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion of bin_in; sampled only while busy=0
- bin_in  input  BIN_W  binary value; captured on the accepted start cycle
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse when bcd_out is updated
- bcd_out  output  4*DIGITS  packed BCD; [3:0]=ones, [7:4]=tens, etc.; registered
- overflow  output  1  registered; high when the last converted bin_in > 10^DIGITS-1

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, internal shift/scratch/iteration counter cleared. Reset mid-conversion aborts the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1: load the shift register with bin_in, clear the BCD scratch, set iter=0, compute overflow_next=(bin_in > 10^DIGITS-1), go to SHIFT, busy=1 next cycle.
  - start=0: remain in IDLE.
- SHIFT, one iteration per cycle:
  - Each scratch nibble >=5 gets +3.
  - Then {scratch, shift} shifts left by 1, with the MSB of shift entering scratch bit 0.
  - The bit shifted out of the top nibble is discarded, so the result is bin_in mod 10^DIGITS.
  - iter increments each cycle. After iteration BIN_W-1 completes, go to DONE.
- DONE (one cycle): bcd_out<=scratch, overflow<=overflow_next, done=1, busy=0, then return to IDLE.
- Latency: start accepted at cycle 0 gives done=1 and the new bcd_out visible at cycle BIN_W+1 (15 for the default). The next start can be accepted in the cycle after done.
- A start while busy=1 or in DONE is ignored; it is not queued. bin_in changes after acceptance have no effect.
- done and busy are never both high. done stays high for exactly one cycle.
- bcd_out is stable between done pulses and never shows an intermediate scratch value.
- Every digit nibble of bcd_out is always 0..9.
- Iteration counter width is $clog2(BIN_W+1).

Optional Feature:
- Macro: BIN_TO_BCD_SATURATE_EN.
- Defined: if overflow_next=1, DONE loads bcd_out with all nines (16'h9999 for default) instead of scratch. overflow still asserts.
- Not defined: bcd_out = bin_in mod 10^DIGITS (e.g. 12345 gives 16'h2345). overflow still asserts.
- Latency is the same in both builds.

Decomposition:
- Shared package (gol_display_pkg):
  - state enum {IDLE, SHIFT, DONE}
  - BCD nibble width constant 4
  - DEC_MAX(DIGITS) = 10^DIGITS-1 constant/function
  - all-nines pattern constant used by saturation
- One natural sub-module: bcd_add3_adjust, the combinational per-nibble "if >=5 add 3" applied across all DIGITS nibbles. It is instantiated once and feeds the shift step.
- The FSM and registers stay in bin_to_bcd_seq.

Test Plan:
- Reset, then idle 5 cycles -> bcd_out=16'h0000, busy=0, done=0, overflow=0.
- start with bin_in=1234 -> busy=1 at cycle 1, done pulse at cycle 15, bcd_out=16'h1234, overflow=0. Also check bin_in=0 gives 16'h0000 and bin_in=9999 gives 16'h9999.
- bin_in=12345 -> overflow=1. Without the macro bcd_out=16'h2345; with BIN_TO_BCD_SATURATE_EN bcd_out=16'h9999.
- Start bin_in=42; pulse start with bin_in=77 at cycle 5 and change bin_in -> second start ignored, bcd_out=16'h0042 at cycle 15. Start 77 in the cycle after done -> 16'h0077 15 cycles later.
- Start bin_in=500 after a prior result of 16'h1234; assert reset at cycle 7 -> no done pulse, bcd_out=16'h0000, busy=0. Next start with 500 -> 16'h0500.
- Back-to-back starts 0..9999 (random 200 values) vs. a decimal model -> every bcd_out matches, every nibble <=9, done always exactly 1 cycle.
